pgm_rom_loader: RTL and testbench
=================================

Name: pgm_rom_loader

Overview:
- Bridges the HPS ioctl download stream (16-bit words, indexed by ROM type) into SDRAM write requests.
- Sits between hps_io and the SDRAM controller.
- Maps each ioctl_index to a fixed SDRAM region and buffers words in a small FIFO, so SDRAM refresh and arbitration stalls never drop data.
- Holds the CPUs in reset until every word is committed, then raises rom_ready.

Parameters:
- FIFO_DEPTH, 4, words buffered between ioctl and SDRAM (power of two, minimum 2)
- AW, 24, SDRAM word-address width

Ports:
- clk_sys  in  1  system clock, shared with hps_io
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  one-cycle strobe: ioctl_addr/ioctl_dout valid
- ioctl_addr  in  27  byte address within the current ROM
- ioctl_dout  in  16  data word
- ioctl_index  in  8  ROM type selector
- ioctl_wait  out  1  back-pressure to HPS
- mem_req  out  1  SDRAM write request
- mem_addr  out  AW  SDRAM word address
- mem_din  out  16  write data
- mem_ack  in  1  one-cycle accept pulse from the SDRAM controller
- rom_ready  out  1  all downloaded words committed
- load_done  out  1  one-cycle pulse when a download completes
- load_err  out  1  sticky error flag, cleared at download start
- word_cnt  out  24  words committed in the current download

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Reset asserted mid-operation: mem_req drops immediately (asynchronous); no further requests until reset is released.
- Region map, by ioctl_index:
  - 0 (BIOS): base 0x000000, limit 0x040000 words
  - 1 (68k P-ROM): base 0x040000, limit 0x3C0000
  - 2 (tile/sprite): base 0x400000, limit 0x800000
  - 3 (samples): base 0xC00000, limit 0x400000
- Word address = base + ioctl_addr[24:1], computed modulo 2^AW.
- Drop rules (word not pushed, load_err set):
  - index greater than 3
  - ioctl_addr[0] = 1
  - ioctl_addr[26:1] >= limit
- Download start: ioctl_download is registered. A rising edge seen in IDLE or DONE enters LOAD and in the same cycle clears word_cnt, load_err and rom_ready.
- FIFO push: ioctl_wr in LOAD with no drop condition pushes {addr, data}.
  - A push while the FIFO is full is discarded and sets load_err; data is never overwritten.
  - Push and pop in the same cycle are both legal; the count is unchanged.
- ioctl_wait = 1 when FIFO count >= FIFO_DEPTH-1. This reserves one slot for an ioctl_wr already in flight.
- Output handshake:
  - A registered output stage loads the FIFO head when empty.
  - Next cycle, mem_req = 1 with mem_addr/mem_din held stable until mem_ack.
  - On mem_ack, word_cnt is incremented; the next head is presented no earlier than the following cycle (at most one word per 2 cycles).
  - mem_ack while mem_req = 0 is ignored.
- States:
  - IDLE: no activity. Download rising edge -> LOAD.
  - LOAD: accepts pushes. ioctl_download falling -> DRAIN.
  - DRAIN: ioctl_wr ignored. FIFO empty and output stage idle -> DONE.
  - DONE: exactly 1 cycle. load_done = 1 and rom_ready is set. Next cycle -> IDLE, or -> LOAD if a rising edge is registered in that cycle.
- A download of zero words still passes LOAD -> DRAIN -> DONE, with word_cnt = 0.
- The top level drives the CPU reset from ~rom_ready.

Decomposition:
- Shared package pgm_pkg:
  - region base/limit constants and ROM index constants (IDX_BIOS, IDX_PROM, IDX_GFX, IDX_SND)
  - the loader state enum
- One sub-module: pgm_sync_fifo. It is a parameterised width/depth synchronous FIFO with full, empty and count outputs, and is reused by later stages.
- The address mapper stays inline as combinational logic.

Test Plan:
- Basic load, mem_ack returned 1 cycle after every mem_req: index 1, 4 words at byte addr 0,2,4,6 with data 0x1111..0x4444. Writes go to 0x040000..0x040003 in order; word_cnt = 4; load_done pulses once; rom_ready = 1.
- Back-pressure: mem_ack withheld for 20 cycles during a burst of 8 writes. ioctl_wait rises when count reaches 3; no data is lost; all 8 writes appear in order once acks resume.
- Illegal inputs, one write each: index 5; odd addr 0x3; index 0 at byte addr 0x80000. None of the three produces mem_req; load_err = 1. A following valid write still commits, and load_err stays set.
- Drain: ioctl_download falls while 3 words remain buffered. State is DRAIN; rom_ready stays 0 until the 3rd mem_ack; load_done pulses the cycle after.
- Reset mid-burst: reset_n low while mem_req = 1. mem_req drops in the same cycle, all outputs are 0 and the FIFO is empty. A new download after release starts at word_cnt = 0.
- Back-to-back downloads: index 0 completes, then index 2 starts in the DONE cycle. rom_ready clears, word_cnt resets, and writes go to base 0x400000.

Source files
------------

// File: rtl/pgm_pkg.sv
// Shared definitions for the PGM ROM download path: ROM index codes,
// the SDRAM region map (word base / word limit per index) and the
// loader state encoding.
package pgm_pkg;

    // ioctl_index codes delivered by hps_io
    localparam logic [7:0] IDX_BIOS = 8'd0;
    localparam logic [7:0] IDX_PROM = 8'd1;
    localparam logic [7:0] IDX_GFX  = 8'd2;
    localparam logic [7:0] IDX_SND  = 8'd3;

    // SDRAM word base of each region
    localparam logic [23:0] BASE_BIOS = 24'h000000;
    localparam logic [23:0] BASE_PROM = 24'h040000;
    localparam logic [23:0] BASE_GFX  = 24'h400000;
    localparam logic [23:0] BASE_SND  = 24'hC00000;

    // Region size in words; wide enough to compare against ioctl_addr[26:1]
    localparam logic [25:0] LIM_BIOS = 26'h040000;
    localparam logic [25:0] LIM_PROM = 26'h3C0000;
    localparam logic [25:0] LIM_GFX  = 26'h800000;
    localparam logic [25:0] LIM_SND  = 26'h400000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ldr_state_e;

    typedef struct packed {
        logic        vld;
        logic [23:0] base;
        logic [25:0] limit;
    } region_t;

    // Unknown indices come back with vld=0 and limit=0, so any address
    // compares as out of range as well.
    function automatic region_t region_lookup(input logic [7:0] idx);
        region_t r;
        r.vld   = 1'b1;
        r.base  = '0;
        r.limit = '0;
        case (idx)
            IDX_BIOS: begin r.base = BASE_BIOS; r.limit = LIM_BIOS; end
            IDX_PROM: begin r.base = BASE_PROM; r.limit = LIM_PROM; end
            IDX_GFX:  begin r.base = BASE_GFX;  r.limit = LIM_GFX;  end
            IDX_SND:  begin r.base = BASE_SND;  r.limit = LIM_SND;  end
            default:  r.vld = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pgm_sync_fifo.sv
// Purpose: generic single-clock FIFO with full/empty/count status.
// Latency: a pushed entry is visible on rd_dat the cycle after the push.
// Backpressure: push while full is discarded (no overwrite); pop while empty is ignored.
//
// Ports: clk/rst_n (async active-low), wr_vld/wr_dat push side,
//        rd_rdy pop strobe with rd_dat showing the head, full/empty/count status.
module pgm_sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = wr_vld && !full;
    assign do_pop  = rd_rdy && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage needs no reset: nothing is read until count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pgm_rom_loader.sv
// Purpose: turns the hps_io ioctl download stream into SDRAM word writes per ROM region.
// Latency: 2 cycles from ioctl_wr to mem_req when the output stage is idle; at most one word per 2 cycles.
// Backpressure: ioctl_wait once FIFO holds FIFO_DEPTH-1 words; mem_req held with stable addr/data until mem_ack.
//
// Ports: clk_sys/reset_n (async active-low); ioctl_* download input and ioctl_wait;
//        mem_req/mem_addr/mem_din/mem_ack SDRAM write port; rom_ready, load_done,
//        load_err, word_cnt status. The system top holds the CPUs in reset on ~rom_ready.
module pgm_rom_loader
    import pgm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 24
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [26:0]   ioctl_addr,
    input  logic [15:0]   ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    input  logic          mem_ack,
    output logic          rom_ready,
    output logic          load_done,
    output logic          load_err,
    output logic [23:0]   word_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   dat;
    } wr_ent_t;

    ldr_state_e    state;
    logic          dl_q;
    logic          dl_rise;
    logic          dl_fall;

    region_t       region;
    logic          drop;
    logic          wr_take;
    logic          push_vld;
    wr_ent_t       push_ent;

    logic          pop_rdy;
    wr_ent_t       head_ent;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;

    logic          mem_hs;
    logic          stage_free_next;

    // ---------------------------------------------------------------
    // Download edge detection against the registered copy
    // ---------------------------------------------------------------
    assign dl_rise = ioctl_download && !dl_q;
    assign dl_fall = !ioctl_download && dl_q;

    // ---------------------------------------------------------------
    // Address mapper: region lookup, range/alignment screening
    // ---------------------------------------------------------------
    always_comb begin
        region = region_lookup(ioctl_index);
        // Full 26-bit word offset is compared so addresses beyond bit 24
        // are caught even though they do not reach the SDRAM address.
        drop   = !region.vld || ioctl_addr[0] || (ioctl_addr[26:1] >= region.limit);
        push_ent.addr = AW'(region.base) + AW'(ioctl_addr[24:1]);
        push_ent.dat  = ioctl_dout;
    end

    assign wr_take  = (state == ST_LOAD) && ioctl_wr;
    assign push_vld = wr_take && !drop;

    // One slot stays free for a write HPS already launched before it saw wait.
    assign ioctl_wait = (fifo_cnt >= CW'(FIFO_DEPTH - 1));

    // ---------------------------------------------------------------
    // Word buffer
    // ---------------------------------------------------------------
    // The output stage only refills when it is empty, so a word acked this
    // cycle leaves the stage idle for one cycle before the next head.
    assign pop_rdy = !mem_req && !fifo_empty;
    assign mem_hs  = mem_req && mem_ack;

    // True when the output stage will hold nothing after this edge.
    assign stage_free_next = !mem_req || mem_ack;

    pgm_sync_fifo #(
        .W     ($bits(wr_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .wr_vld (push_vld),
        .wr_dat (push_ent),
        .rd_rdy (pop_rdy),
        .rd_dat (head_ent),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    // ---------------------------------------------------------------
    // Loader FSM, output stage and status registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            dl_q      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rom_ready <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            dl_q      <= ioctl_download;
            load_done <= 1'b0;

            // Output stage: present head, hold until accepted.
            if (mem_hs) begin
                mem_req  <= 1'b0;
                word_cnt <= word_cnt + 24'd1;
            end else if (pop_rdy) begin
                mem_req  <= 1'b1;
                mem_addr <= head_ent.addr;
                mem_din  <= head_ent.dat;
            end

            // Dropped word or overflow; the FIFO itself refuses the push.
            if (wr_take && (drop || fifo_full)) begin
                load_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (dl_rise) begin
                        state     <= ST_LOAD;
                        word_cnt  <= '0;
                        load_err  <= 1'b0;
                        rom_ready <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (dl_fall) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave as soon as the final ack lands so load_done
                    // follows the last commit by a single cycle.
                    if (fifo_empty && stage_free_next) begin
                        state     <= ST_DONE;
                        load_done <= 1'b1;
                        rom_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (dl_rise) begin
                        state     <= ST_LOAD;
                        word_cnt  <= '0;
                        load_err  <= 1'b0;
                        rom_ready <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_rom_loader.sv
// Purpose: directed bench for pgm_rom_loader with a word-stream model and per-cycle compare.
// Latency: inputs driven 1 time unit after clk_sys rise; outputs compared on clk_sys fall.
// Backpressure: writes honour ioctl_wait like HPS; mem_ack is gated by ack_en to stall SDRAM.
module tb_pgm_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_ack = 1'b0;
    logic        rom_ready;
    logic        load_done;
    logic        load_err;
    logic [23:0] word_cnt;

    pgm_rom_loader #(.FIFO_DEPTH(4), .AW(24)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_ack        (mem_ack),
        .rom_ready      (rom_ready),
        .load_done      (load_done),
        .load_err       (load_err),
        .word_cnt       (word_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- model state ----------------
    typedef struct packed {
        logic [23:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt = 0;
    bit   exp_err   = 0;
    int   done_cnt  = 0;
    bit   prev_done = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    bit   ack_en    = 1;
    bit   stray_ack = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT event did not occur within cycle budget", nm);
    endtask

    // Region table and drop rules, straight from the address map.
    function automatic bit model_map(input int idx, input logic [26:0] byte_a,
                                     output logic [23:0] waddr);
        longint base;
        longint limit;
        longint w;
        waddr = '0;
        case (idx)
            0: begin base = 64'h000000; limit = 64'h040000; end
            1: begin base = 64'h040000; limit = 64'h3C0000; end
            2: begin base = 64'h400000; limit = 64'h800000; end
            3: begin base = 64'hC00000; limit = 64'h400000; end
            default: return 0;
        endcase
        if (byte_a % 2 != 0) return 0;
        w = longint'(byte_a) / 2;
        if (w >= limit) return 0;
        waddr = 24'((base + w) % 64'h1000000);
        return 1;
    endfunction

    // ---------------- SDRAM ack responder ----------------
    always @(posedge clk_sys) begin
        #1;
        mem_ack = stray_ack || (mem_req && ack_en);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            chk("reset_ctl", {ioctl_wait, mem_req, rom_ready, load_done, load_err}, 5'b0);
            chk("reset_data", {mem_addr, mem_din, word_cnt}, 64'h0);
        end else begin
            chk("word_cnt", word_cnt, model_cnt);
            if (load_done) begin
                chk("done_pulse_width", prev_done, 0);
                done_cnt++;
            end
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_req", mem_req, 0);
                end else begin
                    chk("mem_addr", mem_addr, exp_q[0].a);
                    chk("mem_din", mem_din, exp_q[0].d);
                    if (mem_ack) begin
                        void'(exp_q.pop_front());
                        model_cnt++;
                    end
                end
            end
        end
        prev_done = load_done;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr(input logic [7:0] idx, input logic [26:0] a, input logic [15:0] d);
        logic [23:0] wa;
        int t;
        t = 0;
        while (ioctl_wait === 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (ioctl_wait !== 1'b0) timeout("ioctl_wait_release");
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        if (model_map(int'(idx), a, wa)) exp_q.push_back('{a: wa, d: d});
        else exp_err = 1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
        model_cnt = 0;
        exp_err   = 0;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    // Returns on the falling edge of the DONE cycle.
    task automatic wait_done(input int words);
        int t;
        t = 0;
        do begin
            @(negedge clk_sys);
            t++;
        end while (load_done !== 1'b1 && t < 300);
        if (load_done !== 1'b1) begin
            timeout("load_done");
        end else begin
            chk("done_rom_ready", rom_ready, 1);
            chk("done_word_cnt", word_cnt, words);
            chk("done_err_model", load_err, exp_err);
        end
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        do begin
            @(negedge clk_sys);
            t++;
        end while (mem_req !== 1'b1 && t < 100);
        if (mem_req !== 1'b1) timeout("mem_req");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int t;

        repeat (3) @(posedge clk_sys);
        #3 reset_n = 1'b1;
        tick();
        chk("rst_rom_ready", rom_ready, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_mem_req", mem_req, 0);

        // Basic load, index 1
        d0 = done_cnt;
        start_dl();
        wr(8'd1, 27'h0, 16'h1111);
        wait_req();
        chk("basic_first_addr", mem_addr, 24'h040000);
        chk("basic_first_data", mem_din, 16'h1111);
        tick();
        for (int i = 1; i < 4; i++) wr(8'd1, 27'(2 * i), 16'(16'h1111 * (i + 1)));
        end_dl();
        wait_done(4);
        tick();
        chk("basic_done_once", done_cnt, d0 + 1);
        chk("basic_done_low", load_done, 0);
        chk("basic_err", load_err, 0);

        // Stray ack with no request pending
        stray_ack = 1;
        @(posedge clk_sys);
        #2 stray_ack = 0;
        repeat (3) tick();
        chk("stray_ack_cnt", word_cnt, 24'd4);

        // Illegal inputs, then a valid boundary write
        start_dl();
        wr(8'd5, 27'h0, 16'hAAAA);
        wr(8'd1, 27'h3, 16'hBBBB);
        wr(8'd0, 27'h80000, 16'hCCCC);
        repeat (6) tick();
        chk("illegal_err", load_err, 1);
        chk("illegal_err_model", load_err, exp_err);
        chk("illegal_cnt", word_cnt, 0);
        wr(8'd0, 27'h7FFFE, 16'hDDDD);
        wait_req();
        chk("bios_top_addr", mem_addr, 24'h03FFFF);
        tick();
        end_dl();
        wait_done(1);
        chk("illegal_err_sticky", load_err, 1);
        tick();

        // Back-pressure: SDRAM stalled during an 8-word burst
        ack_en = 0;
        start_dl();
        for (int i = 0; i < 4; i++) begin
            wr(8'd1, 27'(27'h100 + 2 * i), 16'(16'hB000 + i));
            chk("bp_wait_step", ioctl_wait, (i == 3));
        end
        repeat (16) tick();
        chk("bp_wait_held", ioctl_wait, 1);
        chk("bp_req_held", mem_req, 1);
        chk("bp_addr_held", mem_addr, 24'h040080);
        chk("bp_cnt_held", word_cnt, 0);
        ack_en = 1;
        for (int i = 4; i < 8; i++) wr(8'd1, 27'(27'h100 + 2 * i), 16'(16'hB000 + i));
        end_dl();
        wait_done(8);
        tick();

        // Drain with 3 words buffered
        ack_en = 0;
        start_dl();
        chk("drain_rom_cleared", rom_ready, 0);
        for (int i = 0; i < 3; i++) wr(8'd2, 27'(2 * i), 16'(16'hC000 + i));
        repeat (2) tick();
        end_dl();
        repeat (4) tick();
        chk("drain_rom_ready", rom_ready, 0);
        chk("drain_done", load_done, 0);
        chk("drain_req", mem_req, 1);
        ack_en = 1;
        t = 0;
        do begin
            @(negedge clk_sys);
            t++;
            if (word_cnt < 24'd3) chk("drain_rom_early", rom_ready, 0);
        end while (word_cnt < 24'd3 && t < 100);
        if (word_cnt < 24'd3) timeout("drain_commit");
        chk("drain_done_pulse", load_done, 1);
        chk("drain_rom_set", rom_ready, 1);
        @(negedge clk_sys);
        chk("drain_done_clear", load_done, 0);
        tick();

        // Reset mid-burst
        ack_en = 0;
        start_dl();
        wr(8'd1, 27'h0, 16'hE000);
        wr(8'd1, 27'h2, 16'hE001);
        wait_req();
        @(posedge clk_sys);
        #3;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        exp_err   = 0;
        #1;
        chk("rst_async_req", mem_req, 0);
        chk("rst_async_wait", ioctl_wait, 0);
        chk("rst_async_addr", mem_addr, 0);
        repeat (3) @(posedge clk_sys);
        #3 reset_n = 1'b1;
        ack_en = 1;
        repeat (4) tick();
        chk("post_rst_req", mem_req, 0);
        start_dl();
        chk("post_rst_cnt", word_cnt, 0);
        wr(8'd3, 27'h7FFFFE, 16'h5A5A);
        wr(8'd3, 27'h800000, 16'hA5A5);
        wait_req();
        chk("snd_top_addr", mem_addr, 24'hFFFFFF);
        chk("snd_top_data", mem_din, 16'h5A5A);
        tick();
        end_dl();
        wait_done(1);
        chk("snd_limit_err", load_err, 1);
        tick();

        // Zero-word download
        start_dl();
        end_dl();
        wait_done(0);
        chk("zero_err", load_err, 0);
        tick();

        // Back-to-back: index 0, then index 2 started in the DONE cycle
        start_dl();
        wr(8'd0, 27'h0, 16'h1234);
        wr(8'd0, 27'h2, 16'h5678);
        end_dl();
        wait_done(2);
        ioctl_download = 1'b1;
        tick();
        model_cnt = 0;
        exp_err   = 0;
        chk("b2b_rom_clear", rom_ready, 0);
        chk("b2b_cnt_clear", word_cnt, 0);
        chk("b2b_done_low", load_done, 0);
        wr(8'd2, 27'h10, 16'h9ABC);
        wait_req();
        chk("b2b_gfx_addr", mem_addr, 24'h400008);
        tick();
        wr(8'd2, 27'h12, 16'hDEF0);
        end_dl();
        wait_done(2);
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
